pwm_dac_mc: RTL and testbench

//  Multi-channel PWM audio DAC: successor to the single-channel aud_pwm driver in z1top.

---
 rtl/pwm_dac_mc_pkg.sv | 21 ++
 rtl/pwm_dac_mc_channel.sv | 47 ++++
 rtl/pwm_dac_mc.sv | 169 ++++++++++++++++
 tb/tb_pwm_dac_mc.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_dac_mc_pkg.sv
// pwm_dac_mc_pkg
//   Shared definitions for the multi-channel PWM audio DAC.
//   Provides the alignment-mode encodings, the counter direction enum and a
//   helper that returns the terminal count for a given resolution.
//   No ports (package).
package pwm_dac_mc_pkg;

    localparam int MODE_EDGE   = 0;
    localparam int MODE_CENTER = 1;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    // Largest value the period counter reaches for a WIDTH-bit duty.
    function automatic int unsigned max_count(input int unsigned width);
        return (32'd1 << width) - 32'd1;
    endfunction

endpackage

// File: rtl/pwm_dac_mc_channel.sv
// pwm_dac_mc_channel
//   One PWM channel: pending (double-buffer) duty register, active duty
//   register, the counter comparison and the registered output.
// Ports
//   clk          in   1      system clock
//   reset        in   1      asynchronous reset, active-high
//   enable       in   1      output forced low while deasserted
//   cnt          in   WIDTH  shared period counter
//   sample       in   WIDTH  this channel's slice of the incoming sample
//   load_pend    in   1      capture sample into the pending register
//   load_active  in   1      copy pending duty into the active register
//   pwm_out      out  1      registered PWM output
module pwm_dac_mc_channel #(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] cnt,
    input  logic [WIDTH-1:0] sample,
    input  logic             load_pend,
    input  logic             load_active,
    output logic             pwm_out
);

    logic [WIDTH-1:0] pend_duty;
    logic [WIDTH-1:0] active_duty;

    // The top never raises load_pend and load_active together, so the
    // pending register is never overwritten while it is being consumed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_duty   <= '0;
            active_duty <= '0;
            pwm_out     <= 1'b0;
        end else begin
            if (load_pend) begin
                pend_duty <= sample;
            end
            if (load_active) begin
                active_duty <= pend_duty;
            end
            pwm_out <= enable && (cnt < active_duty);
        end
    end

endmodule

// File: rtl/pwm_dac_mc.sv
// pwm_dac_mc
//   Multi-channel PWM audio DAC. Holds the shared prescaler, period counter
//   (edge-aligned sawtooth or center-aligned up/down), the sample handshake
//   and the boundary pulses; each channel lives in pwm_dac_mc_channel.
//   New samples are double-buffered and only take effect at a period
//   boundary so outputs never glitch mid-period.
// Ports
//   clk           in   1               system clock
//   reset         in   1               asynchronous reset, active-high
//   enable        in   1               run PWM; low holds counters, outputs low
//   sample_in     in   CHANNELS*WIDTH  packed duties, channel k at [k*WIDTH +: WIDTH]
//   sample_valid  in   1               sample_in valid
//   sample_ready  out  1               pending buffer empty
//   pwm_out       out  CHANNELS        registered PWM outputs
//   period_start  out  1               pulse coincident with counter back at 0
//   underrun      out  1               pulse: boundary reached with nothing pending
//   irq           out  1               (only with PWM_IRQ_EN) level, set when the
//                                      buffer needs refilling, cleared on accept
// Configuration macro: PWM_IRQ_EN adds the irq port and its register.
module pwm_dac_mc
    import pwm_dac_mc_pkg::*;
#(
    parameter int CHANNELS       = 2,
    parameter int WIDTH          = 10,
    parameter int CLK_DIV        = 1,
    parameter int CENTER_ALIGNED = 0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [CHANNELS*WIDTH-1:0] sample_in,
    input  logic                      sample_valid,
    output logic                      sample_ready,
    output logic [CHANNELS-1:0]       pwm_out,
    output logic                      period_start,
    output logic                      underrun
`ifdef PWM_IRQ_EN
    ,
    output logic                      irq
`endif
);

    localparam int               PW         = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0]    PRESC_LAST = PW'(CLK_DIV - 1);
    localparam logic [PW-1:0]    PRESC_ONE  = PW'(1);
    localparam logic [WIDTH-1:0] CNT_MAX    = WIDTH'(max_count(WIDTH));
    localparam logic [WIDTH-1:0] CNT_ONE    = WIDTH'(1);

    logic [PW-1:0]    presc;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] cnt_next;
    dir_t             dir;
    dir_t             dir_next;
    logic             pend_full;
    logic             tick;
    logic             boundary;
    logic             accept;
    logic             load_active;

    assign tick         = enable && (presc == PRESC_LAST);
    assign sample_ready = !pend_full;
    assign accept       = sample_valid && !pend_full;
    assign load_active  = boundary && pend_full;

    // Prescaler: a free-running divider that is held at zero while disabled
    // so a re-enable always starts a clean, full-length period.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc <= '0;
        end else if (!enable || (presc == PRESC_LAST)) begin
            presc <= '0;
        end else begin
            presc <= presc + PRESC_ONE;
        end
    end

    // Counter/direction state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
            dir <= DIR_UP;
        end else begin
            cnt <= cnt_next;
            dir <= dir_next;
        end
    end

    // Next counter value and boundary detection. In center mode the boundary
    // is the step from 1 down to 0, so the period is 2*(2^WIDTH-1) ticks and
    // the terminal count is visited only once per period.
    always_comb begin
        cnt_next = cnt;
        dir_next = dir;
        boundary = 1'b0;
        if (!enable) begin
            cnt_next = '0;
            dir_next = DIR_UP;
        end else if (tick) begin
            if (CENTER_ALIGNED == MODE_CENTER) begin
                if (dir == DIR_UP) begin
                    if (cnt == CNT_MAX) begin
                        cnt_next = cnt - CNT_ONE;
                        dir_next = DIR_DOWN;
                    end else begin
                        cnt_next = cnt + CNT_ONE;
                    end
                end else begin
                    cnt_next = cnt - CNT_ONE;
                    if (cnt == CNT_ONE) begin
                        dir_next = DIR_UP;
                        boundary = 1'b1;
                    end
                end
            end else begin
                cnt_next = cnt + CNT_ONE;
                boundary = (cnt == CNT_MAX);
            end
        end
    end

    // Handshake and boundary pulses. A boundary with a full buffer consumes
    // it; an accept in the same cycle as an empty-buffer boundary still
    // fills the buffer, and that boundary reports an underrun.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_full    <= 1'b0;
            period_start <= 1'b0;
            underrun     <= 1'b0;
        end else begin
            period_start <= boundary;
            underrun     <= boundary && !pend_full;
            if (load_active) begin
                pend_full <= 1'b0;
            end else if (accept) begin
                pend_full <= 1'b1;
            end
        end
    end

`ifdef PWM_IRQ_EN
    // Refill request: raised when a boundary leaves the buffer empty, dropped
    // as soon as the CPU hands over a new sample.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq <= 1'b0;
        end else if (accept) begin
            irq <= 1'b0;
        end else if ((underrun || period_start) && !pend_full) begin
            irq <= 1'b1;
        end
    end
`endif

    for (genvar k = 0; k < CHANNELS; k++) begin : g_chan
        pwm_dac_mc_channel #(
            .WIDTH(WIDTH)
        ) u_chan (
            .clk        (clk),
            .reset      (reset),
            .enable     (enable),
            .cnt        (cnt),
            .sample     (sample_in[k*WIDTH +: WIDTH]),
            .load_pend  (accept),
            .load_active(load_active),
            .pwm_out    (pwm_out[k])
        );
    end

endmodule

// File: tb/tb_pwm_dac_mc.sv
// tb_pwm_dac_mc
//   Drives three pwm_dac_mc instances (WIDTH=4, 2 channels) from shared
//   stimulus: edge-aligned CLK_DIV=1, center-aligned CLK_DIV=1 and
//   edge-aligned CLK_DIV=4. Each is compared every cycle against a model
//   that derives the counter position arithmetically from the number of
//   enabled clocks and tracks the sample buffer as a simple scoreboard.
//   With PWM_IRQ_EN defined the irq output is also modelled and compared.
module tb_pwm_dac_mc;

    localparam int W    = 4;
    localparam int CH   = 2;
    localparam int NI   = 3;
    localparam int MAXC = (1 << W) - 1;

    logic            clk = 1'b0;
    logic            reset;
    logic            enable;
    logic            sample_valid;
    logic [CH*W-1:0] sample_in;
    logic [CH-1:0]   pwm [NI];
    logic            ready [NI];
    logic            ps [NI];
    logic            ur [NI];
`ifdef PWM_IRQ_EN
    logic            irq [NI];
`endif

    int div_cfg [NI] = '{1, 1, 4};
    int ctr_cfg [NI] = '{0, 1, 0};

    int j_m       [NI];
    int pend_full [NI];
    int pend_m    [NI][CH];
    int act_m     [NI][CH];
    int exp_pwm   [NI][CH];
    int exp_ps    [NI];
    int exp_ur    [NI];
    int irq_m     [NI];

    int n_vec = 0;
    int n_err = 0;
    int hi0, hi1, ps2;

    always #5 clk = ~clk;

    pwm_dac_mc #(.CHANNELS(CH), .WIDTH(W), .CLK_DIV(1), .CENTER_ALIGNED(0)) u_edge (
        .clk(clk), .reset(reset), .enable(enable), .sample_in(sample_in),
        .sample_valid(sample_valid), .sample_ready(ready[0]), .pwm_out(pwm[0]),
        .period_start(ps[0]), .underrun(ur[0])
`ifdef PWM_IRQ_EN
        , .irq(irq[0])
`endif
    );

    pwm_dac_mc #(.CHANNELS(CH), .WIDTH(W), .CLK_DIV(1), .CENTER_ALIGNED(1)) u_center (
        .clk(clk), .reset(reset), .enable(enable), .sample_in(sample_in),
        .sample_valid(sample_valid), .sample_ready(ready[1]), .pwm_out(pwm[1]),
        .period_start(ps[1]), .underrun(ur[1])
`ifdef PWM_IRQ_EN
        , .irq(irq[1])
`endif
    );

    pwm_dac_mc #(.CHANNELS(CH), .WIDTH(W), .CLK_DIV(4), .CENTER_ALIGNED(0)) u_div4 (
        .clk(clk), .reset(reset), .enable(enable), .sample_in(sample_in),
        .sample_valid(sample_valid), .sample_ready(ready[2]), .pwm_out(pwm[2]),
        .period_start(ps[2]), .underrun(ur[2])
`ifdef PWM_IRQ_EN
        , .irq(irq[2])
`endif
    );

    task automatic check_output(input string tag, input int actual, input int expected);
        n_vec++;
        if (actual != expected) begin
            n_err++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    // Ticks in one PWM period for instance i.
    function automatic int period_ticks(input int i);
        return (ctr_cfg[i] != 0) ? 2 * MAXC : MAXC + 1;
    endfunction

    // Counter value after n ticks: a sawtooth, or a triangle folded at MAXC.
    function automatic int cnt_at(input int i, input int n);
        int p, q;
        p = period_ticks(i);
        q = n % p;
        if (ctr_cfg[i] != 0) begin
            return (q <= MAXC) ? q : p - q;
        end
        return q;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            j_m[i]       = 0;
            pend_full[i] = 0;
            exp_ps[i]    = 0;
            exp_ur[i]    = 0;
            irq_m[i]     = 0;
            for (int k = 0; k < CH; k++) begin
                pend_m[i][k]  = 0;
                act_m[i][k]   = 0;
                exp_pwm[i][k] = 0;
            end
        end
    endtask

    // One clock edge of the reference, using inputs as seen at that edge.
    task automatic model_edge();
        int n, bnd, acc, evt;
        for (int i = 0; i < NI; i++) begin
            evt = ((exp_ps[i] != 0) || (exp_ur[i] != 0)) && (pend_full[i] == 0);
            bnd = 0;
            if (enable) begin
                n   = j_m[i] / div_cfg[i];
                bnd = ((j_m[i] % div_cfg[i]) == div_cfg[i] - 1) &&
                      (((n + 1) % period_ticks(i)) == 0);
                for (int k = 0; k < CH; k++) begin
                    exp_pwm[i][k] = (cnt_at(i, n) < act_m[i][k]) ? 1 : 0;
                end
                j_m[i]++;
            end else begin
                for (int k = 0; k < CH; k++) begin
                    exp_pwm[i][k] = 0;
                end
                j_m[i] = 0;
            end
            exp_ps[i] = bnd;
            exp_ur[i] = (bnd != 0) && (pend_full[i] == 0);
            acc = sample_valid && (pend_full[i] == 0);
            if (acc != 0) begin
                irq_m[i] = 0;
            end else if (evt != 0) begin
                irq_m[i] = 1;
            end
            if ((bnd != 0) && (pend_full[i] != 0)) begin
                for (int k = 0; k < CH; k++) begin
                    act_m[i][k] = pend_m[i][k];
                end
                pend_full[i] = 0;
            end else if (acc != 0) begin
                for (int k = 0; k < CH; k++) begin
                    pend_m[i][k] = int'(sample_in[k*W +: W]);
                end
                pend_full[i] = 1;
            end
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < NI; i++) begin
            for (int k = 0; k < CH; k++) begin
                check_output($sformatf("inst%0d_pwm%0d", i, k), int'(pwm[i][k]), exp_pwm[i][k]);
            end
            check_output($sformatf("inst%0d_period_start", i), int'(ps[i]), exp_ps[i]);
            check_output($sformatf("inst%0d_underrun", i), int'(ur[i]), exp_ur[i]);
            check_output($sformatf("inst%0d_ready", i), int'(ready[i]), (pend_full[i] == 0) ? 1 : 0);
`ifdef PWM_IRQ_EN
            check_output($sformatf("inst%0d_irq", i), int'(irq[i]), irq_m[i]);
`endif
        end
    endtask

    function automatic logic [W-1:0] pick_duty();
        int r;
        r = $urandom_range(0, 5);
        if (r == 0) return '0;
        if (r == 1) return W'(MAXC);
        return W'($urandom_range(0, MAXC));
    endfunction

    task automatic apply_stimulus(input bit rnd);
        if (!rnd) begin
            sample_valid = 1'b0;
            return;
        end
        if (!enable) begin
            enable = ($urandom_range(0, 4) == 0);
        end else begin
            enable = !($urandom_range(0, 299) == 0);
        end
        sample_valid = ($urandom_range(0, 9) == 0);
        for (int k = 0; k < CH; k++) begin
            sample_in[k*W +: W] = pick_duty();
        end
    endtask

    task automatic run_cycles(input int n, input bit rnd);
        repeat (n) begin
            @(posedge clk);
            if (reset) model_reset();
            else model_edge();
            #1;
            apply_stimulus(rnd);
            @(negedge clk);
            check_all();
            hi0 += int'(pwm[0][0]);
            hi1 += int'(pwm[0][1]);
            ps2 += int'(ps[2]);
        end
    endtask

    // Asynchronous reset mid-period; outputs must clear before any clock edge.
    task automatic do_reset_mid();
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check_all();
        run_cycles(1, 1'b0);
        reset = 1'b0;
    endtask

    initial begin
        reset        = 1'b1;
        enable       = 1'b0;
        sample_valid = 1'b0;
        sample_in    = '0;
        hi0 = 0; hi1 = 0; ps2 = 0;
        model_reset();
        run_cycles(2, 1'b0);
        reset = 1'b0;

        // Duties 4 / 15 on the edge instance: 4 and 15 high clocks per 16.
        enable       = 1'b1;
        sample_in    = {4'd15, 4'd4};
        sample_valid = 1'b1;
        run_cycles(16, 1'b0);
        hi0 = 0; hi1 = 0;
        run_cycles(16, 1'b0);
        check_output("edge_ch0_high_clks", hi0, 4);
        check_output("edge_ch1_high_clks", hi1, 15);

        // Duties 0 / 15: ch0 never high, ch1 low exactly one clock.
        sample_in    = {4'd15, 4'd0};
        sample_valid = 1'b1;
        run_cycles(16, 1'b0);
        hi0 = 0; hi1 = 0;
        run_cycles(16, 1'b0);
        check_output("edge_duty0_high_clks", hi0, 0);
        check_output("edge_dutymax_high_clks", hi1, 15);

        // Divide-by-4 instance: one period_start every 64 clocks.
        ps2 = 0;
        run_cycles(128, 1'b0);
        check_output("div4_period_starts", ps2, 2);

        // Sample arriving in the same cycle as an underrun boundary.
        run_cycles(15, 1'b0);
        sample_in    = {4'd8, 4'd8};
        sample_valid = 1'b1;
        run_cycles(1, 1'b0);
        check_output("simul_underrun", int'(ur[0]), 1);
        check_output("simul_ready_low", int'(ready[0]), 0);
        run_cycles(15, 1'b0);
        check_output("simul_ready_still_low", int'(ready[0]), 0);
        run_cycles(1, 1'b0);
        check_output("simul_applied", int'(ready[0]), 1);

        // Randomized operation with resets landing while a sample is pending.
        for (int r = 0; r < 4; r++) begin
            run_cycles(400, 1'b1);
            sample_valid = 1'b1;
            run_cycles(1, 1'b0);
            do_reset_mid();
            enable = 1'b1;
        end
        run_cycles(200, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
